// File: rtl/risc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : risc_mem_responder
// Brief    : Instruction/data memory responder for a RISC core, with a
//            byte-stream program loader that holds the core while loading.
//            Optional MMIO GPIO register enabled by macro RISC_MEM_MMIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module risc_mem_responder #(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] INST_PC,
   output logic [31:0] INSTRUCTION_MEM_OUT,
   input  logic [31:0] RAM_IN_ADDRESS,
   input  logic [31:0] RAM_IN_DATA,
   input  logic        RAM_IN_WRITE,
   output logic [31:0] RAM_OUT,
   input  logic        ld_start,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [7:0]  ld_byte,
   input  logic        ld_last,
   output logic        core_hold,
   output logic        core_clr,
   output logic        ld_overflow,
   output logic [7:0]  gpio_out
);

   localparam int          c_IAW       = $clog2(IMEM_DEPTH);
   localparam int          c_DAW       = $clog2(DMEM_DEPTH);
   localparam logic [31:0] c_NOP       = 32'h0000_0013;
   localparam logic [c_IAW:0] c_PTR_FULL = (c_IAW+1)'(IMEM_DEPTH);
   localparam logic [c_IAW:0] c_PTR_ONE  = {{c_IAW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0] r_imem [IMEM_DEPTH];
   logic [31:0] r_dmem [DMEM_DEPTH];

   logic [c_IAW:0] r_ptr;
   logic [1:0]     r_idx;
   logic [31:0]    r_word;
   logic           r_overflow;

   logic           w_beat;
   logic           w_word_done;
   logic           w_ptr_full;
   logic           w_imem_we;
   logic [31:0]    w_asm;
   logic           w_imem_hit;
   logic           w_dmem_hit;
   logic           w_dmem_we;
   logic [31:0]    w_dmem_rd;

   // ---------------------------------------------------------------- loader FSM
   always_ff @(posedge clk) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ld_ready    = 1'b0;
      core_hold   = 1'b0;
      core_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ld_start) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            ld_ready  = 1'b1;
            core_hold = 1'b1;
            if (ld_valid && ld_last) w_state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            core_hold   = 1'b1;
            core_clr    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_word only ever holds bytes below r_idx, so unfilled upper bytes stay zero
   assign w_beat      = (r_state == S_LOAD) && ld_valid;
   assign w_word_done = w_beat && ((r_idx == 2'd3) || ld_last);
   assign w_asm       = r_word | (32'(ld_byte) << {r_idx, 3'b000});
   assign w_ptr_full  = (r_ptr == c_PTR_FULL);
   assign w_imem_we   = w_word_done && !w_ptr_full && !clr;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_ptr      <= '0;
         r_idx      <= '0;
         r_word     <= '0;
         r_overflow <= 1'b0;
      end else if ((r_state == S_IDLE) && ld_start) begin
         r_ptr      <= '0;
         r_idx      <= '0;
         r_word     <= '0;
         r_overflow <= 1'b0;
      end else if (w_beat) begin
         if (w_word_done) begin
            r_idx  <= '0;
            r_word <= '0;
            // Pointer saturates at depth so excess words never wrap onto imem[0]
            if (w_ptr_full) r_overflow <= 1'b1;
            else            r_ptr      <= r_ptr + c_PTR_ONE;
         end else begin
            r_idx  <= r_idx + 2'd1;
            r_word <= w_asm;
         end
      end
   end

   assign ld_overflow = r_overflow;

   // ---------------------------------------------------------------- memories
   always_ff @(posedge clk) begin
      if (w_imem_we) r_imem[r_ptr[c_IAW-1:0]] <= w_asm;
   end

   assign w_imem_hit = (INST_PC < 32'(IMEM_DEPTH));
   assign INSTRUCTION_MEM_OUT = core_hold  ? c_NOP :
                                w_imem_hit ? r_imem[INST_PC[c_IAW-1:0]] : 32'h0;

   assign w_dmem_hit = (RAM_IN_ADDRESS < 32'(DMEM_DEPTH));
   assign w_dmem_we  = RAM_IN_WRITE && !core_hold && w_dmem_hit;
   assign w_dmem_rd  = w_dmem_hit ? r_dmem[RAM_IN_ADDRESS[c_DAW-1:0]] : 32'h0;

   always_ff @(posedge clk) begin
      if (w_dmem_we) r_dmem[RAM_IN_ADDRESS[c_DAW-1:0]] <= RAM_IN_DATA;
   end

`ifdef RISC_MEM_MMIO_EN
   localparam logic [31:0] c_MMIO_ADDR = 32'hFFFF_FFFF;
   logic [7:0] r_gpio;

   always_ff @(posedge clk) begin
      if (clr)
         r_gpio <= '0;
      else if (RAM_IN_WRITE && !core_hold && (RAM_IN_ADDRESS == c_MMIO_ADDR))
         r_gpio <= RAM_IN_DATA[7:0];
   end

   assign gpio_out = r_gpio;
   assign RAM_OUT  = (RAM_IN_ADDRESS == c_MMIO_ADDR) ? {24'h0, r_gpio} : w_dmem_rd;
`else
   assign gpio_out = 8'h00;
   assign RAM_OUT  = w_dmem_rd;
`endif

endmodule
`default_nettype wire

// File: doc/risc_mem_responder.md
RISC_MEM_RESPONDER -- requirements
Module: risc_mem_responder

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, instruction memory depth in 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter DMEM_DEPTH, default 64, data memory depth in 32-bit words (power of 2, >=4).
REQ-003 SHALL use one clock and a synchronous, active-high reset; port list follows.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 clr  in  1  synchronous active-high reset.
REQ-006 INST_PC  in  32  instruction word address from core.
REQ-007 INSTRUCTION_MEM_OUT  out  32  instruction word to core.
REQ-008 RAM_IN_ADDRESS  in  32  data word address from core.
REQ-009 RAM_IN_DATA  in  32  store data from core.
REQ-010 RAM_IN_WRITE  in  1  store strobe from core.
REQ-011 RAM_OUT  out  32  load data to core.
REQ-012 ld_start  in  1  begin program load (pulse).
REQ-013 ld_valid / ld_ready  in / out  1 / 1  loader byte handshake.
REQ-014 ld_byte  in  8  program byte, little-endian within word.
REQ-015 ld_last  in  1  qualifies final byte of image.
REQ-016 core_hold  out  1  core must freeze while high.
REQ-017 core_clr  out  1  one-cycle reset pulse to core after load.
REQ-018 ld_overflow  out  1  sticky: image exceeded IMEM_DEPTH.
REQ-019 gpio_out  out  8  memory-mapped output register (see Configuration).

Function
REQ-020 Reads SHALL be combinational: INSTRUCTION_MEM_OUT = imem[INST_PC], RAM_OUT = dmem[RAM_IN_ADDRESS], same cycle, so core pipeline registers capture them at the next edge.
REQ-021 Addresses >= depth SHALL read 0x00000000; out-of-range stores SHALL be ignored (no aliasing/wrap).
REQ-022 Stores SHALL commit at the rising edge when RAM_IN_WRITE=1 and core_hold=0; a same-cycle read of that address returns the old word.
REQ-023 Loader FSM states: IDLE, LOAD, RELEASE.
REQ-024 IDLE: ld_ready=0, core_hold=0; ld_start=1 -> LOAD, word pointer and byte index cleared to 0, ld_overflow cleared.
REQ-025 LOAD: ld_ready=1, core_hold=1; each ld_valid&ld_ready beat places ld_byte at bits [8*idx+7:8*idx], idx increments.
REQ-026 On the 4th byte, or on a beat with ld_last=1, assembled word (unfilled upper bytes zero) SHALL be written to imem[pointer] at that edge; pointer increments, idx returns to 0.
REQ-027 If pointer = IMEM_DEPTH at word write, word SHALL be dropped and ld_overflow set; bytes continue to be accepted (drain).
REQ-028 Beat with ld_last=1 -> RELEASE; ld_start during LOAD or RELEASE SHALL be ignored.
REQ-029 RELEASE lasts exactly one cycle: core_hold=1, core_clr=1; then IDLE.
REQ-030 While core_hold=1, INSTRUCTION_MEM_OUT SHALL read 0x00000013 (NOP) and core stores SHALL be ignored.

Reset
REQ-031 clr=1 SHALL force IDLE, pointer=0, idx=0, ld_overflow=0, core_hold=0, core_clr=0, ld_ready=0, gpio_out=0.
REQ-032 Memory arrays SHALL NOT be cleared by clr; a reset mid-load leaves already-written words intact and discards the partial word.

Configuration
REQ-033 Macro RISC_MEM_MMIO_EN defined: store to address 0xFFFFFFFF latches RAM_IN_DATA[7:0] into gpio_out; load from 0xFFFFFFFF returns {24'b0, gpio_out}.
REQ-034 Macro undefined: 0xFFFFFFFF is ordinary out-of-range (store ignored, read 0); gpio_out tied to 0.

Verification
REQ-035 Reset then INST_PC=0 with default memory -> core_hold=0, ld_ready=0, ld_overflow=0, gpio_out=0x00.
REQ-036 ld_start; bytes 0x93,0x00,0x50,0x00 then 0x13,0x00 with ld_last -> imem[0]=0x00500093, imem[1]=0x00000013, one-cycle core_clr, then IDLE.
REQ-037 Store 0xDEADBEEF to address 5, same-cycle read 5 returns old value, next cycle RAM_OUT=0xDEADBEEF; store to address 64 ignored, read 64 returns 0.
REQ-038 Load 65 words (IMEM_DEPTH=64) -> ld_overflow=1, imem[0..63] written, 65th word dropped; during load INSTRUCTION_MEM_OUT=0x00000013 and core stores ignored.
REQ-039 clr after 6 bytes of a load -> IDLE, imem[0] retains first word, imem[1] unchanged, ld_ready=0.
REQ-040 With RISC_MEM_MMIO_EN: store 0x000000A5 to 0xFFFFFFFF -> gpio_out=0xA5, read returns 0x000000A5; without macro gpio_out stays 0x00.
